reconfig_icap_feeder: RTL and testbench

- Sits directly downstream of the reconfiguration register block, in the register clock domain.
- Accepts a partial-bitstream byte stream from register writes and packs byte pairs into 16-bit words, high byte first.
- Buffers the words in a small FIFO and drives a Spartan-6 ICAP write port at up to one word per clock, honouring ICAP busy.
- Provides flush (pad odd byte), abort, and status (word count, FIFO level, busy) for readback through the register interface.

---
 rtl/reconfig_icap_feeder.sv | 223 ++++++++++++++++++++++
 tb/tb_reconfig_icap_feeder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reconfig_icap_feeder.sv
// -----------------------------------------------------------------------------
// reconfig_icap_feeder
//
// Packs a partial-bitstream byte stream into 16-bit words, high byte first,
// buffers them in a small FIFO and drives a Spartan-6 ICAP write port at up to
// one word per clock while honouring ICAP busy. Everything runs on the
// register clock.
//
// Byte handshake: a byte transfers on a rising edge where byte_valid_i and
// byte_ready_o are both high. byte_ready_o is combinational and does not
// depend on byte_valid_i. The producer may hold byte_valid_i high
// indefinitely, and byte_i must stay stable until the transfer edge.
//
// Ports:
//   clk              register clock, rising edge
//   reset_i          synchronous active-high reset
//   byte_i           bitstream byte
//   byte_valid_i     byte_i valid
//   byte_ready_o     block can accept a byte this cycle
//   flush_i          pulse: pad a pending odd byte with 8'h00 and push it
//   abort_i          pulse: discard all buffered data (same effect as reset)
//   icap_o           ICAP write data (each byte bit-reversed when BITSWAP=1)
//   icap_ce_n_o      ICAP chip enable, active low
//   icap_we_n_o      ICAP write enable, active low (always equals ce_n)
//   icap_busy_i      ICAP busy; the presented word is not consumed while high
//   words_written_o  words consumed by the ICAP, saturating at 16'hFFFF
//   fifo_level_o     FIFO occupancy in words
//   odd_pending_o    high byte held awaiting its pair
//   busy_o           any data in flight
//
// state_q is the packer state and can be observed hierarchically.
// -----------------------------------------------------------------------------
module reconfig_icap_feeder #(
    parameter int FIFO_AW = 4,
    parameter bit BITSWAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset_i,
    input  logic [7:0]         byte_i,
    input  logic               byte_valid_i,
    output logic               byte_ready_o,
    input  logic               flush_i,
    input  logic               abort_i,
    output logic [15:0]        icap_o,
    output logic               icap_ce_n_o,
    output logic               icap_we_n_o,
    input  logic               icap_busy_i,
    output logic [15:0]        words_written_o,
    output logic [FIFO_AW:0]   fifo_level_o,
    output logic               odd_pending_o,
    output logic               busy_o
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no odd byte pending
        ST_HALF  = 2'd1,   // high byte held
        ST_FLUSH = 2'd2    // flush requested, pad word still to be pushed
    } pack_state_t;

    pack_state_t state_q, state_d;

    logic [7:0]          hi_q, hi_d;
    logic                odd_q, odd_d;
    logic                push_req;
    logic [15:0]         push_word;

    logic [15:0]         mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]    level_q;
    logic                fifo_full, fifo_empty;
    logic                push_en, pop;

    logic [15:0]         out_data_q;
    logic                out_valid_q;
    logic                consume, load_slot;
    logic [15:0]         words_q;

    logic                flush_pend;
    logic                accept;
    logic                clear;

    // Level never exceeds DEPTH, so the MSB alone marks "full".
    assign fifo_full  = level_q[FIFO_AW];
    assign fifo_empty = (level_q == '0);
    assign flush_pend = (state_q == ST_FLUSH);
    assign clear      = reset_i || abort_i;

    assign byte_ready_o = !fifo_full && !flush_i && !flush_pend && !abort_i;
    assign accept       = byte_valid_i && byte_ready_o;

    // -------------------------------------------------------------------------
    // Packer / flush FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        odd_d     = odd_q;
        push_req  = 1'b0;
        push_word = {hi_q, byte_i};
        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end else if (accept) begin
                    hi_d    = byte_i;
                    odd_d   = 1'b1;
                    state_d = ST_HALF;
                end
            end
            ST_HALF: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end else if (accept) begin
                    push_req  = 1'b1;
                    push_word = {hi_q, byte_i};
                    odd_d     = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // With nothing pending the flush retires immediately; with an
                // odd byte it waits until the FIFO has room for the pad word.
                if (!odd_q) begin
                    state_d = ST_IDLE;
                end else if (!fifo_full) begin
                    push_req  = 1'b1;
                    push_word = {hi_q, 8'h00};
                    odd_d     = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
            hi_q    <= 8'h00;
            odd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            odd_q   <= odd_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output word register and FIFO control
    // -------------------------------------------------------------------------
    assign consume   = out_valid_q && !icap_busy_i;
    // The register can take a new word when it is empty or being emptied now.
    assign load_slot = consume || !out_valid_q;
    assign pop       = load_slot && !fifo_empty;
    assign push_en   = push_req && (!fifo_full || pop);

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push_en && !clear) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_data_q  <= 16'h0000;
            out_valid_q <= 1'b0;
            words_q     <= 16'h0000;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_en, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase

            if (pop) begin
                out_data_q  <= mem[rd_ptr_q];
                out_valid_q <= 1'b1;
            end else if (load_slot) begin
                out_valid_q <= 1'b0;
            end

            if (consume && (words_q != 16'hFFFF)) begin
                words_q <= words_q + 16'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping. The FIFO holds natural byte order; the ICAP_SPARTAN6
    // bit ordering is applied only at the pins.
    // -------------------------------------------------------------------------
    always_comb begin
        icap_o = out_data_q;
        if (BITSWAP) begin
            for (int i = 0; i < 8; i++) begin
                icap_o[i]     = out_data_q[7 - i];
                icap_o[8 + i] = out_data_q[15 - i];
            end
        end
    end

    assign icap_ce_n_o     = !out_valid_q;
    assign icap_we_n_o     = !out_valid_q;
    assign words_written_o = words_q;
    assign fifo_level_o    = level_q;
    assign odd_pending_o   = odd_q;
    assign busy_o          = out_valid_q || !fifo_empty || odd_q || flush_pend;

endmodule

// File: tb/tb_reconfig_icap_feeder.sv
module tb_reconfig_icap_feeder;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        flush_i;
  logic        abort_i;
  logic        icap_busy_i;

  // Instance with pass-through byte order
  logic        a_byte_ready;
  logic [15:0] a_icap;
  logic        a_ce_n, a_we_n;
  logic [15:0] a_words;
  logic [4:0]  a_level;
  logic        a_odd, a_busy;

  // Instance with bit-reversed byte order
  logic        s_byte_ready;
  logic [15:0] s_icap;
  logic        s_ce_n, s_we_n;
  logic [15:0] s_words;
  logic [4:0]  s_level;
  logic        s_odd, s_busy;

  reconfig_icap_feeder #(.FIFO_AW(4), .BITSWAP(1'b0)) dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .byte_i          (byte_i),
    .byte_valid_i    (byte_valid_i),
    .byte_ready_o    (a_byte_ready),
    .flush_i         (flush_i),
    .abort_i         (abort_i),
    .icap_o          (a_icap),
    .icap_ce_n_o     (a_ce_n),
    .icap_we_n_o     (a_we_n),
    .icap_busy_i     (icap_busy_i),
    .words_written_o (a_words),
    .fifo_level_o    (a_level),
    .odd_pending_o   (a_odd),
    .busy_o          (a_busy)
  );

  reconfig_icap_feeder #(.FIFO_AW(4), .BITSWAP(1'b1)) dut_sw (
    .clk             (clk),
    .reset_i         (reset_i),
    .byte_i          (byte_i),
    .byte_valid_i    (byte_valid_i),
    .byte_ready_o    (s_byte_ready),
    .flush_i         (flush_i),
    .abort_i         (abort_i),
    .icap_o          (s_icap),
    .icap_ce_n_o     (s_ce_n),
    .icap_we_n_o     (s_we_n),
    .icap_busy_i     (icap_busy_i),
    .words_written_o (s_words),
    .fifo_level_o    (s_level),
    .odd_pending_o   (s_odd),
    .busy_o          (s_busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_total = 0;
  int n_pass  = 0;
  int wr_cnt  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_sw_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] rev_bytes(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i]     = w[7 - i];
      r[8 + i] = w[15 - i];
    end
    return r;
  endfunction

  task automatic expect_word(input logic [15:0] w);
    exp_q.push_back(w);
    exp_sw_q.push_back(rev_bytes(w));
  endtask

  // Inputs change at posedge+1, so at the negedge the values seen are the
  // ones the next rising edge will sample: a low ce_n with busy low here is
  // exactly one ICAP write.
  always @(negedge clk) begin
    if (!reset_i && !abort_i && !a_ce_n && !icap_busy_i) begin
      wr_cnt++;
      if (exp_q.size() == 0) check_eq("write_expected", 32'd0, 32'd1);
      else check_eq("wr_data", {16'h0, a_icap}, {16'h0, exp_q.pop_front()});
      check_eq("we_eq_ce", {31'h0, a_we_n}, {31'h0, a_ce_n});
    end
    if (!reset_i && !abort_i && !s_ce_n && !icap_busy_i) begin
      if (exp_sw_q.size() == 0) check_eq("sw_write_expected", 32'd0, 32'd1);
      else check_eq("sw_wr_data", {16'h0, s_icap}, {16'h0, exp_sw_q.pop_front()});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    wait_cycles(2);
    reset_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_i       = b;
    byte_valid_i = 1'b1;
    @(negedge clk);
    while (!a_byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("ready_timeout", 32'd0, 32'd1);
    tick();
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((a_busy || s_busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check_eq("idle_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    @(negedge clk);
    check_eq("ready_during_flush", {31'h0, a_byte_ready}, 32'd0);
    tick();
    flush_i = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  int base;
  logic [15:0] w;
  int n;

  initial begin
    reset_i      = 1'b1;
    byte_i       = 8'hAA;
    byte_valid_i = 1'b1;
    flush_i      = 1'b0;
    abort_i      = 1'b0;
    icap_busy_i  = 1'b0;

    // Reset held with a valid byte on the input
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rst_ce_n", {30'h0, a_ce_n, s_ce_n}, 32'd3);
    end
    check_eq("rst_icap", {16'h0, a_icap}, 32'd0);
    check_eq("rst_we_n", {31'h0, a_we_n}, 32'd1);
    check_eq("rst_words", {16'h0, a_words}, 32'd0);
    check_eq("rst_level", {27'h0, a_level}, 32'd0);
    check_eq("rst_odd", {31'h0, a_odd}, 32'd0);
    check_eq("rst_busy", {31'h0, a_busy}, 32'd0);
    tick();
    byte_valid_i = 1'b0;
    reset_i      = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", {31'h0, a_byte_ready}, 32'd1);
    check_eq("odd_after_rst", {31'h0, a_odd}, 32'd0);
    tick();

    // Back-to-back stream AA 99 55 66
    base = wr_cnt;
    expect_word(16'hAA99);
    expect_word(16'h5566);
    send_byte(8'hAA);
    send_byte(8'h99);
    send_byte(8'h55);
    send_byte(8'h66);
    wait_idle();
    check_eq("stream_writes", wr_cnt - base, 32'd2);
    check_eq("stream_words", {16'h0, a_words}, 32'd2);
    check_eq("stream_busy", {31'h0, a_busy}, 32'd0);

    // Bit-reversed ordering: 01 80 -> 8001
    expect_word(16'h0180);
    send_byte(8'h01);
    send_byte(8'h80);
    n = 0;
    @(negedge clk);
    while (s_ce_n && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("swap_word", {16'h0, s_icap}, 32'h8001);
    check_eq("noswap_word", {16'h0, a_icap}, 32'h0180);
    wait_idle();

    // Fill with ICAP busy: 17 words, register + full FIFO
    do_reset();
    icap_busy_i = 1'b1;
    base = wr_cnt;
    for (int k = 0; k < 17; k++) begin
      w = {8'h40 + 8'(k), 8'hC0 + 8'(k)};
      expect_word(w);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    @(negedge clk);
    check_eq("full_level", {27'h0, a_level}, 32'd16);
    check_eq("full_ready", {31'h0, a_byte_ready}, 32'd0);
    check_eq("full_ce_n", {31'h0, a_ce_n}, 32'd0);
    check_eq("full_icap", {16'h0, a_icap}, 32'h40C0);
    wait_cycles(3);
    @(negedge clk);
    check_eq("busy_hold_icap", {16'h0, a_icap}, 32'h40C0);
    check_eq("busy_hold_words", {16'h0, a_words}, 32'd0);
    tick();
    icap_busy_i = 1'b0;
    wait_idle();
    check_eq("drain_writes", wr_cnt - base, 32'd17);
    check_eq("drain_words", {16'h0, a_words}, 32'd17);
    check_eq("drain_level", {27'h0, a_level}, 32'd0);

    // Flush of an odd byte
    base = wr_cnt;
    expect_word(16'h3000);
    send_byte(8'h30);
    @(negedge clk);
    check_eq("odd_before_flush", {31'h0, a_odd}, 32'd1);
    tick();
    pulse_flush();
    @(negedge clk);
    check_eq("ready_flush_pend", {31'h0, a_byte_ready}, 32'd0);
    tick();
    wait_idle();
    check_eq("flush_writes", wr_cnt - base, 32'd1);
    check_eq("flush_odd", {31'h0, a_odd}, 32'd0);
    check_eq("flush_words", {16'h0, a_words}, 32'd18);

    // Flush with nothing pending
    base = wr_cnt;
    pulse_flush();
    wait_cycles(5);
    check_eq("empty_flush_writes", wr_cnt - base, 32'd0);
    check_eq("empty_flush_busy", {31'h0, a_busy}, 32'd0);

    // Abort with 5 words buffered and a byte offered in the abort cycle
    icap_busy_i = 1'b1;
    for (int k = 0; k < 10; k++) send_byte(8'h10 + 8'(k));
    @(negedge clk);
    check_eq("pre_abort_level", {27'h0, a_level}, 32'd4);
    tick();
    abort_i      = 1'b1;
    byte_valid_i = 1'b1;
    byte_i       = 8'hEE;
    @(negedge clk);
    check_eq("abort_ready", {31'h0, a_byte_ready}, 32'd0);
    tick();
    abort_i      = 1'b0;
    byte_valid_i = 1'b0;
    @(negedge clk);
    check_eq("abort_level", {27'h0, a_level}, 32'd0);
    check_eq("abort_words", {16'h0, a_words}, 32'd0);
    check_eq("abort_ce_n", {31'h0, a_ce_n}, 32'd1);
    check_eq("abort_odd", {31'h0, a_odd}, 32'd0);
    check_eq("abort_busy", {31'h0, a_busy}, 32'd0);
    check_eq("abort_icap", {16'h0, a_icap}, 32'd0);
    tick();
    base = wr_cnt;
    icap_busy_i = 1'b0;
    wait_cycles(6);
    check_eq("post_abort_writes", wr_cnt - base, 32'd0);
    check_eq("post_abort_words", {16'h0, a_words}, 32'd0);

    check_eq("exp_q_empty", exp_q.size(), 32'd0);
    check_eq("exp_sw_q_empty", exp_sw_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute time limit as a backstop against a stalled run
  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d/%0d checks passed, required completion", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
